// File: rtl/mod_cascade_counter.sv
// Cascade of programmable-modulus digit counters (mixed radix) with clear, load,
// registered wrap pulse and per-digit runtime modulus. Define MODCNT_DOWN_EN to add dir/down-counting.
module mod_cascade_counter #(
  parameter int STAGES      = 2,
  parameter int WIDTH       = 3,
  parameter int MOD_DEFAULT = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     load,
  input  logic [STAGES*WIDTH-1:0]  load_val,
  input  logic                     cfg_we,
  input  logic [STAGES*WIDTH-1:0]  cfg_mod,
`ifdef MODCNT_DOWN_EN
  input  logic                     dir,
`endif
  output logic [STAGES*WIDTH-1:0]  count,
  output logic [STAGES-1:0]        stage_tc,
  output logic                     last,
  output logic                     wrap
);

  // One extra modulus bit so MOD_DEFAULT may equal 2^WIDTH.
  localparam logic [WIDTH:0] MOD_RST = (WIDTH+1)'(MOD_DEFAULT);

  logic [WIDTH-1:0] cnt_q    [STAGES];
  logic [WIDTH:0]   mod_q    [STAGES];
  logic [WIDTH:0]   mod_m1   [STAGES];
  logic [WIDTH-1:0] step_val [STAGES];
  logic [WIDTH-1:0] load_d   [STAGES];
  logic [STAGES-1:0] tc;
  logic [STAGES-1:0] degen;
  logic [STAGES:0]   carry;
  logic              down;

`ifdef MODCNT_DOWN_EN
  assign down = dir;
`else
  assign down = 1'b0;
`endif

  // carry[k] means digit k steps on this edge: en and every lower digit terminal.
  always_comb begin
    logic go;
    go    = en;
    carry = '0;
    tc    = '0;
    degen = '0;
    count = '0;
    for (int k = 0; k < STAGES; k++) begin
      mod_m1[k]   = mod_q[k] - (WIDTH+1)'(1);
      degen[k]    = (mod_q[k] <= (WIDTH+1)'(1));
      step_val[k] = '0;
      load_d[k]   = '0;
      if (degen[k])
        tc[k] = 1'b1;
      else if (down)
        tc[k] = (cnt_q[k] == '0);
      else
        tc[k] = ({1'b0, cnt_q[k]} >= mod_m1[k]);
      if (degen[k])
        step_val[k] = '0;
      else if (down)
        step_val[k] = (cnt_q[k] == '0) ? mod_m1[k][WIDTH-1:0] : cnt_q[k] - WIDTH'(1);
      else
        step_val[k] = tc[k] ? '0 : cnt_q[k] + WIDTH'(1);
      if ({1'b0, load_val[k*WIDTH +: WIDTH]} < mod_q[k])
        load_d[k] = load_val[k*WIDTH +: WIDTH];
      carry[k] = go;
      go       = go & tc[k];
      count[k*WIDTH +: WIDTH] = cnt_q[k];
    end
    carry[STAGES] = go;
  end

  assign stage_tc = tc;
  assign last     = carry[STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        cnt_q[k] <= '0;
        mod_q[k] <= MOD_RST;
      end
      wrap <= 1'b0;
    end else begin
      // A modulus write only affects steps from the following edge onward.
      for (int k = 0; k < STAGES; k++)
        if (cfg_we) mod_q[k] <= {1'b0, cfg_mod[k*WIDTH +: WIDTH]};
      if (clr) begin
        for (int k = 0; k < STAGES; k++) cnt_q[k] <= '0;
        wrap <= 1'b0;
      end else if (load) begin
        for (int k = 0; k < STAGES; k++) cnt_q[k] <= load_d[k];
        wrap <= 1'b0;
      end else begin
        for (int k = 0; k < STAGES; k++)
          if (carry[k]) cnt_q[k] <= step_val[k];
        wrap <= last;
      end
    end
  end

endmodule

// File: tb/tb_mod_cascade_counter.sv
// Bench for mod_cascade_counter: vector table, directed corner sequences and
// randomized traffic checked against a digit-level reference model.
module tb_mod_cascade_counter;

  localparam int STAGES = 2;
  localparam int WIDTH  = 3;
  localparam int W      = STAGES*WIDTH;

  logic         clk = 1'b0;
  logic         rst, en, clr, load, cfg_we, dir;
  logic [W-1:0] load_val, cfg_mod;
  logic [W-1:0] count;
  logic [STAGES-1:0] stage_tc;
  logic         last, wrap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_cascade_counter #(.STAGES(STAGES), .WIDTH(WIDTH), .MOD_DEFAULT(5)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .cfg_we(cfg_we), .cfg_mod(cfg_mod),
`ifdef MODCNT_DOWN_EN
    .dir(dir),
`endif
    .count(count), .stage_tc(stage_tc), .last(last), .wrap(wrap)
  );

  typedef struct packed {
    logic         rst, en, clr, load, cfg_we;
    logic [W-1:0] load_val, cfg_mod, exp_count;
    logic         exp_wrap;
  } vec_t;

  vec_t vecs [11];
  logic [W-1:0] exp_q[$];

  // reference model state
  int md [STAGES];
  int mm [STAGES];
  bit mw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pk(input int d1, input int d0);
    return W'((d1 << WIDTH) | d0);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; en = 0; clr = 0; load = 0; cfg_we = 0; dir = 0;
    tick();
    rst = 0;
  endtask

  function automatic bit m_tc(input int k);
    if (mm[k] <= 1) return 1'b1;
    if (dir) return md[k] == 0;
    return md[k] >= mm[k] - 1;
  endfunction

  function automatic bit m_last();
    bit all = en;
    for (int k = 0; k < STAGES; k++) all = all && m_tc(k);
    return all;
  endfunction

  function automatic logic [W-1:0] m_count();
    int v = 0;
    for (int k = 0; k < STAGES; k++) v = v | (md[k] << (k*WIDTH));
    return W'(v);
  endfunction

  function automatic logic [STAGES-1:0] m_stage_tc();
    logic [STAGES-1:0] v;
    for (int k = 0; k < STAGES; k++) v[k] = m_tc(k);
    return v;
  endfunction

  task automatic m_step();
    bit tcs [STAGES];
    bit go, lst;
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin md[k] = 0; mm[k] = 5; end
      mw = 0;
    end else begin
      lst = m_last();
      for (int k = 0; k < STAGES; k++) tcs[k] = m_tc(k);
      if (clr) begin
        for (int k = 0; k < STAGES; k++) md[k] = 0;
        mw = 0;
      end else if (load) begin
        for (int k = 0; k < STAGES; k++) begin
          int f = int'((load_val >> (k*WIDTH)) & 7);
          md[k] = (f < mm[k]) ? f : 0;
        end
        mw = 0;
      end else begin
        go = en;
        for (int k = 0; k < STAGES; k++) begin
          if (go) begin
            if (mm[k] <= 1)  md[k] = 0;
            else if (dir)    md[k] = (md[k] == 0) ? mm[k] - 1 : md[k] - 1;
            else             md[k] = tcs[k] ? 0 : md[k] + 1;
          end
          go = go && tcs[k];
        end
        mw = lst;
      end
      if (cfg_we)
        for (int k = 0; k < STAGES; k++) mm[k] = int'((cfg_mod >> (k*WIDTH)) & 7);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int wraps;
    rst = 0; en = 0; clr = 0; load = 0; cfg_we = 0; dir = 0;
    load_val = '0; cfg_mod = '0;

    // {rst,en,clr,load,cfg_we,load_val,cfg_mod,exp_count,exp_wrap}, default moduli 5/5
    vecs[0]  = '{1, 0, 0, 0, 0, pk(0,0), pk(0,0), pk(0,0), 0};
    vecs[1]  = '{0, 1, 0, 0, 0, pk(0,0), pk(0,0), pk(0,1), 0};
    vecs[2]  = '{0, 1, 0, 1, 0, pk(2,6), pk(0,0), pk(2,0), 0};
    vecs[3]  = '{0, 1, 0, 0, 0, pk(0,0), pk(0,0), pk(2,1), 0};
    vecs[4]  = '{0, 0, 1, 1, 0, pk(3,3), pk(0,0), pk(0,0), 0};
    vecs[5]  = '{0, 0, 0, 1, 0, pk(4,4), pk(0,0), pk(4,4), 0};
    vecs[6]  = '{0, 1, 0, 0, 0, pk(0,0), pk(0,0), pk(0,0), 1};
    vecs[7]  = '{0, 0, 0, 0, 0, pk(0,0), pk(0,0), pk(0,0), 0};
    vecs[8]  = '{0, 0, 0, 1, 0, pk(4,4), pk(0,0), pk(4,4), 0};
    vecs[9]  = '{0, 1, 1, 0, 0, pk(0,0), pk(0,0), pk(0,0), 0};
    vecs[10] = '{1, 1, 0, 0, 0, pk(0,0), pk(0,0), pk(0,0), 0};

    @(negedge clk);
    foreach (vecs[i]) begin
      rst = vecs[i].rst; en = vecs[i].en; clr = vecs[i].clr; load = vecs[i].load;
      cfg_we = vecs[i].cfg_we; load_val = vecs[i].load_val; cfg_mod = vecs[i].cfg_mod;
      tick();
      chk($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
      chk($sformatf("vec%0d_wrap", i), wrap, vecs[i].exp_wrap);
    end

    // Default moduli: 25-count cycle, single wrap pulse after 44 -> 00
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_stage_tc", stage_tc, 0);
    chk("rst_last_en_low", last, 0);
    en = 1;
    wraps = 0;
    for (int t = 0; t <= 26; t++) begin
      #1;
      chk("def_count", count, pk((t % 25) / 5, t % 5));
      chk("def_last", last, (t % 25) == 24);
      chk("def_wrap", wrap, (t > 0) && (t % 25 == 0));
      wraps += int'(wrap);
      tick();
    end
    chk("def_wrap_once", wraps, 1);

    // Runtime modulus {3,4}: period 12
    do_reset();
    cfg_we = 1; cfg_mod = pk(3, 4);
    tick();
    cfg_we = 0; en = 1;
    for (int t = 0; t < 30; t++) begin
      #1;
      chk("m34_count", count, pk((t / 4) % 3, t % 4));
      chk("m34_d0_range", count[WIDTH-1:0] <= 3, 1);
      chk("m34_wrap", wrap, (t > 0) && (t % 12 == 0));
      tick();
    end

    // Modulus shrink with digit 0 above the new terminal value
    do_reset();
    load = 1; load_val = pk(0, 4);
    tick();
    load = 0; cfg_we = 1; cfg_mod = pk(5, 3);
    tick();
    cfg_we = 0;
    chk("shrink_hold", count, pk(0, 4));
    chk("shrink_tc0", stage_tc[0], 1);
    en = 1;
    tick();
    en = 0;
    chk("shrink_step", count, pk(1, 0));

    // en on the cfg_we edge still uses the old modulus
    do_reset();
    load = 1; load_val = pk(0, 3);
    tick();
    load = 0; en = 1; cfg_we = 1; cfg_mod = pk(5, 3);
    tick();
    cfg_we = 0;
    chk("cfg_edge_old_mod", count, pk(0, 4));
    tick();
    en = 0;
    chk("cfg_edge_new_mod", count, pk(1, 0));

    // m=1 on digit 0: digit 1 advances every enabled cycle
    do_reset();
    cfg_we = 1; cfg_mod = pk(5, 1);
    tick();
    cfg_we = 0; en = 1;
    for (int t = 0; t < 7; t++) begin
      #1;
      chk("m1_tc0", stage_tc[0], 1);
      chk("m1_count", count, pk(t % 5, 0));
      chk("m1_wrap", wrap, (t > 0) && (t % 5 == 0));
      tick();
    end

    // All moduli 1: continuous wrap while en high
    do_reset();
    cfg_we = 1; cfg_mod = pk(1, 1);
    tick();
    cfg_we = 0; en = 1;
    for (int t = 0; t < 4; t++) begin
      #1;
      chk("m11_last", last, 1);
      chk("m11_wrap", wrap, t > 0);
      tick();
    end

`ifdef MODCNT_DOWN_EN
    // Down counting from reset: 00 -> 44 -> 43 -> 42
    do_reset();
    dir = 1; en = 1;
    #1;
    chk("dn_last0", last, 1);
    chk("dn_count0", count, pk(0, 0));
    tick();
    chk("dn_count1", count, pk(4, 4));
    chk("dn_wrap1", wrap, 1);
    tick();
    chk("dn_count2", count, pk(4, 3));
    chk("dn_wrap2", wrap, 0);
    tick();
    chk("dn_count3", count, pk(4, 2));
    dir = 0;
`endif

    // Randomized traffic against the reference model
    for (int k = 0; k < STAGES; k++) begin md[k] = 0; mm[k] = 5; end
    mw = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        chk("rnd_count", count, exp_q.pop_front());
        chk("rnd_wrap", wrap, mw);
      end
      rst      = (i == 0) || ($urandom_range(0, 99) == 0);
      en       = $urandom_range(0, 3) != 0;
      clr      = $urandom_range(0, 39) == 0;
      load     = $urandom_range(0, 19) == 0;
      cfg_we   = $urandom_range(0, 29) == 0;
      load_val = W'($urandom_range(0, (1 << W) - 1));
      cfg_mod  = W'($urandom_range(0, (1 << W) - 1));
`ifdef MODCNT_DOWN_EN
      dir      = $urandom_range(0, 1) == 1;
`else
      dir      = 0;
`endif
      #1;
      if (i > 0) begin
        chk("rnd_stage_tc", stage_tc, m_stage_tc());
        chk("rnd_last", last, m_last());
      end
      @(posedge clk);
      m_step();
      exp_q.push_back(m_count());
    end
    @(negedge clk);
    chk("rnd_count_final", count, exp_q.pop_front());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
